writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//   Drives the register-file write port from two result sources: single-cycle ALU results
//   and multi-cycle slow results from load/divide. ALU results have priority; colliding slow
//   results queue in a small FIFO. A pending-destination scoreboard lets decode stall on
//   RAW hazards against in-flight slow ops. Sits between execute/memory and reg_file.
// PARAMETERS
//   XLEN   32  data width of results and rf_write_data
//   DEPTH  4   slow-result FIFO entries (power of 2, >=2)
// PORTS
//   clk            in   1     core clock; outputs update on posedge, reg_file samples on negedge
//   reset_n        in   1     asynchronous active-low reset
//   alu_valid      in   1     ALU result present this cycle (always accepted, no ready)
//   alu_rd         in   5     ALU destination register
//   alu_data       in   XLEN  ALU result
//   slow_valid     in   1     slow result offered
//   slow_ready     out  1     slow result accepted when slow_valid&&slow_ready; = !fifo_full
//   slow_rd        in   5     slow destination register
//   slow_data      in   XLEN  slow result
//   issue_valid    in   1     slow op issued; marks issue_rd pending
//   issue_rd       in   5     destination of issued slow op
//   rs1_addr       in   5     decode source 1 query
//   rs2_addr       in   5     decode source 2 query
//   rs1_busy       out  1     combinational: pending[rs1_addr]
//   rs2_busy       out  1     combinational: pending[rs2_addr]
//   rf_write_enable out 1     registered write strobe to reg_file
//   rf_write_addr  out  5     registered write address
//   rf_write_data  out  XLEN  registered write data
// BEHAVIOUR
//   - Reset (async, reset_n=0): rf_write_* = 0, FIFO empty, pending[] all 0, slow_ready=1.
//   - Per posedge, select in priority: alu_valid > FIFO head > incoming slow (FIFO empty).
//     Selected entry -> rf_write_* next cycle (latency 1); none -> rf_write_enable=0.
//   - Accepted slow result not selected this cycle is pushed; order of slow results preserved,
//     incoming slow never overtakes queued entries. Push and pop in same cycle legal when full
//     (slow_ready already 0 then, so no push occurs); count stays within 0..DEPTH.
//   - rd==0: never marked pending; entry still consumed but rf_write_enable held 0.
//   - Scoreboard: issue_valid sets pending[issue_rd]; slow entry written clears pending[rd].
//     Same rd set and clear in one cycle: set wins (newer op outstanding).
//   - rs*_busy also asserted if the matching rd is the slow entry being written this cycle
//     (clear takes effect next cycle) unless WB_BYPASS_EN forwards it.
//   - ALU write to a pending rd is a protocol violation (decode must stall); assertion fires.
//   - Reset mid-operation: queued entries and pending bits discarded, no partial write.
// CONFIGURATION
//   WB_BYPASS_EN defined: extra outputs fwd_valid/fwd_rd/fwd_data = rf_write_* this cycle;
//     rs*_busy drops in the cycle the matching slow entry is on rf_write_*.
//   Undefined: no fwd_* ports; busy drops the cycle after the write.
// STRUCTURE
//   riscv_pkg: typedef logic[4:0] reg_idx_t; typedef struct packed {reg_idx_t rd;
//     logic[XLEN-1:0] data;} wb_entry_t; localparam NUM_REGS = 32.
//   Sub-module wb_fifo (DEPTH x wb_entry_t, push/pop/full/empty/count, async active-low reset).
// TESTING
//   1 reset_n=0 mid-queue with 3 FIFO entries -> rf_write_enable=0, slow_ready=1, all busy=0.
//   2 alu_valid rd=5 data=0x11 alone -> next cycle rf_write_enable=1 addr=5 data=0x11.
//   3 alu rd=3 and slow rd=7 same cycle -> cycle+1 writes rd3, cycle+2 writes rd7.
//   4 alu_valid held 6 cycles with 5 slow offers -> slow_ready low after 4 queued; drain order kept.
//   5 issue rd=9, query rs1=9 -> busy=1 until slow rd=9 written; rd=0 issue never busy.
//   6 issue rd=9 same cycle as slow rd=9 writeback -> pending[9] remains 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared register-file types and the writeback entry payload.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t            rd;
        logic [XLEN-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding slow results that lost arbitration to the ALU.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: ALU results win, slow results queue in
// wb_fifo, and a pending scoreboard flags RAW hazards on in-flight slow ops.
// Optional feature macro: WB_BYPASS_EN (adds fwd_* ports, busy drops during write).
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              slow_valid,
    output logic              slow_ready,
    input  logic [4:0]        slow_rd,
    input  logic [XLEN-1:0]   slow_data,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
`ifdef WB_BYPASS_EN
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
`endif
    output logic              rf_write_enable,
    output logic [4:0]        rf_write_addr,
    output logic [XLEN-1:0]   rf_write_data
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t              fifo_head;
    wb_entry_t              slow_entry;
    wb_entry_t              sel_entry;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   slow_acc;
    logic                   sel_valid;
    logic                   sel_is_slow;
    logic                   push;
    logic                   pop;
    logic [NUM_REGS-1:0]    pending;
    logic [NUM_REGS-1:0]    pending_nxt;

    assign slow_ready = !fifo_full;
    assign slow_acc   = slow_valid && slow_ready;
    assign slow_entry = '{rd: slow_rd, data: slow_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (slow_entry),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Source select: ALU, then queued slow head, then incoming slow (only when queue empty).
    always_comb begin
        sel_valid   = 1'b0;
        sel_is_slow = 1'b0;
        sel_entry   = '0;
        push        = 1'b0;
        pop         = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_entry = '{rd: alu_rd, data: alu_data};
            push      = slow_acc;
        end else if (!fifo_empty) begin
            sel_valid   = 1'b1;
            sel_is_slow = 1'b1;
            sel_entry   = fifo_head;
            pop         = 1'b1;
            push        = slow_acc;
        end else if (slow_acc) begin
            sel_valid   = 1'b1;
            sel_is_slow = 1'b1;
            sel_entry   = slow_entry;
        end
    end

    // Scoreboard update: a slow write clears its rd, a new issue sets it and wins.
    always_comb begin
        pending_nxt = pending;
        if (sel_is_slow && sel_entry.rd != '0) begin
            pending_nxt[sel_entry.rd] = 1'b0;
        end
        if (issue_valid && issue_rd != '0) begin
            pending_nxt[issue_rd] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_valid = rf_write_enable;
    assign fwd_rd    = rf_write_addr;
    assign fwd_data  = rf_write_data;
    assign rs1_busy  = pending[rs1_addr];
    assign rs2_busy  = pending[rs2_addr];
`else
    logic wb_slow;

    // Keeps the hazard visible while the slow value is still on the write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_slow <= 1'b0;
        end else begin
            wb_slow <= sel_is_slow && (sel_entry.rd != '0);
        end
    end

    assign rs1_busy = pending[rs1_addr] || (wb_slow && rf_write_addr == rs1_addr);
    assign rs2_busy = pending[rs2_addr] || (wb_slow && rf_write_addr == rs2_addr);
`endif

    // Write port and scoreboard registers; rd 0 is consumed without a strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            pending         <= '0;
        end else begin
            rf_write_enable <= sel_valid && (sel_entry.rd != '0);
            rf_write_addr   <= sel_entry.rd;
            rf_write_data   <= sel_entry.data;
            pending         <= pending_nxt;
        end
    end

`ifndef SYNTHESIS
    // Decode must stall an ALU op whose destination still has a slow op in flight.
    alu_to_pending_rd: assert property (@(posedge clk) disable iff (!reset_n)
        (alu_valid && alu_rd != '0) |-> !pending[alu_rd]);

    fifo_count_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        fifo_count <= CNT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with hand-computed expected values.
module tb_writeback_unit;

    logic        clk;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        slow_valid;
    logic        slow_ready;
    logic [4:0]  slow_rd;
    logic [31:0] slow_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
`ifdef WB_BYPASS_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int n_vec = 0;
    int n_err = 0;

    writeback_unit #(.XLEN(32), .DEPTH(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .slow_valid      (slow_valid),
        .slow_ready      (slow_ready),
        .slow_rd         (slow_rd),
        .slow_data       (slow_data),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
`ifdef WB_BYPASS_EN
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data),
`endif
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        slow_valid  = 1'b0;
        slow_rd     = '0;
        slow_data   = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
        check({tag, ".en"}, rf_write_enable, en);
        if (en) begin
            check({tag, ".addr"}, rf_write_addr, rd);
            check({tag, ".data"}, rf_write_data, d);
        end
    endtask

    logic [4:0] exp_order [11];
    int         exp_cnt;
    int         nxt_slow;
    logic       exp_ready;
    logic       exp_pop;
    logic       exp_push;
    logic       busy_on_write;

    initial begin
        idle();
        rs1_addr = '0;
        rs2_addr = '0;
        reset_n  = 1'b0;
        #1;
        check("rst.en", rf_write_enable, 1'b0);
        check("rst.addr", rf_write_addr, 5'd0);
        check("rst.data", rf_write_data, 32'd0);
        check("rst.ready", slow_ready, 1'b1);
        step();
        reset_n = 1'b1;
        step();

        // Lone ALU result, one-cycle latency.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        step();
        check_wr("alu_only", 1'b1, 5'd5, 32'h11);
        idle();
        step();
        check("alu_only.after", rf_write_enable, 1'b0);

        // ALU rd 0: consumed, no strobe.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hdead;
        step();
        check("alu_rd0.en", rf_write_enable, 1'b0);
        idle();

        // ALU and slow collide: ALU first, slow the next cycle.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'ha3;
        slow_valid = 1'b1; slow_rd = 5'd7; slow_data = 32'hb7;
        step();
        check_wr("coll.c1", 1'b1, 5'd3, 32'ha3);
        idle();
        step();
        check_wr("coll.c2", 1'b1, 5'd7, 32'hb7);
        step();
        check("coll.c3.en", rf_write_enable, 1'b0);

        // Slow rd 0 with empty queue: consumed without a strobe.
        slow_valid = 1'b1; slow_rd = 5'd0; slow_data = 32'h55;
        step();
        check("slow_rd0.en", rf_write_enable, 1'b0);
        idle();
        step();

        // Six ALU cycles against five slow offers; queue fills at 4, then drains in order.
        exp_order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
        exp_cnt  = 0;
        nxt_slow = 10;
        for (int i = 0; i < 11; i++) begin
            alu_valid  = (i < 6);
            alu_rd     = (i < 6) ? 5'(i + 1) : 5'd0;
            alu_data   = 32'h100 + 32'(i);
            slow_valid = (nxt_slow <= 14);
            slow_rd    = 5'(nxt_slow);
            slow_data  = 32'h200 + 32'(nxt_slow);
            exp_ready  = (exp_cnt < 4);
            check($sformatf("fill.ready%0d", i), slow_ready, exp_ready);
            exp_pop  = !alu_valid && (exp_cnt > 0);
            exp_push = slow_valid && exp_ready && (alu_valid || exp_cnt > 0);
            step();
            check($sformatf("fill.addr%0d", i), rf_write_addr, exp_order[i]);
            check($sformatf("fill.en%0d", i), rf_write_enable, 1'b1);
            if (i < 6) begin
                check($sformatf("fill.data%0d", i), rf_write_data, 32'h100 + 32'(i));
            end else begin
                check($sformatf("fill.data%0d", i), rf_write_data, 32'h200 + 32'(exp_order[i]));
            end
            if (slow_valid && exp_ready) nxt_slow++;
            exp_cnt = exp_cnt + int'(exp_push) - int'(exp_pop);
        end
        idle();
        step();
        check("fill.drained.en", rf_write_enable, 1'b0);
        check("fill.drained.ready", slow_ready, 1'b1);

        // Scoreboard: rd 9 busy until its slow result is written; rd 0 never busy.
`ifdef WB_BYPASS_EN
        busy_on_write = 1'b0;
`else
        busy_on_write = 1'b1;
`endif
        rs1_addr = 5'd9; rs2_addr = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        check("sb.pre_issue", rs1_busy, 1'b0);
        step();
        check("sb.issued", rs1_busy, 1'b1);
        issue_rd = 5'd0;
        step();
        check("sb.rd0", rs2_busy, 1'b0);
        idle();
        step();
        step();
        check("sb.held", rs1_busy, 1'b1);
        slow_valid = 1'b1; slow_rd = 5'd9; slow_data = 32'h99;
        step();
        check_wr("sb.write", 1'b1, 5'd9, 32'h99);
        check("sb.busy_on_write", rs1_busy, busy_on_write);
        idle();
        step();
        check("sb.cleared", rs1_busy, 1'b0);

        // Reissue of rd 9 in the same cycle its older result is written: stays pending.
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        slow_valid = 1'b1; slow_rd = 5'd9; slow_data = 32'h77;
        step();
        check_wr("sb.setwin.write", 1'b1, 5'd9, 32'h77);
        check("sb.setwin.c1", rs1_busy, 1'b1);
        idle();
        step();
        check("sb.setwin.c2", rs1_busy, 1'b1);

        // Reset with three queued slow entries and pending rds: everything discarded.
        rs1_addr = 5'd20; rs2_addr = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd20;
        for (int i = 0; i < 3; i++) begin
            alu_valid  = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'h300 + 32'(i);
            slow_valid = 1'b1; slow_rd = 5'(20 + i); slow_data = 32'h400 + 32'(i);
            step();
            issue_valid = 1'b0;
        end
        idle();
        check("mid.busy_before", rs1_busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid.en", rf_write_enable, 1'b0);
        check("mid.ready", slow_ready, 1'b1);
        check("mid.rs1_busy", rs1_busy, 1'b0);
        check("mid.rs2_busy", rs2_busy, 1'b0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mid.nodrain%0d", i), rf_write_enable, 1'b0);
        end
        check("mid.rs1_after", rs1_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
